// File: rtl/mem_access.sv
// rtl/mem_access.sv - LC-3 memory-access stage: data-memory handshake for LD/LDR, LDI, ST/STR, STI.
// Indirect ops read a pointer first; every access state aborts after TIMEOUT cycles without Data_ready.
module mem_access #(
  parameter int TIMEOUT = 8
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        start,
  input  logic [1:0]  mem_op,
  input  logic [15:0] M_Addr,
  input  logic [15:0] M_Data,
  input  logic [15:0] Data_dout,
  input  logic        Data_ready,
  output logic        Data_req,
  output logic        Data_rd,
  output logic [15:0] Data_addr,
  output logic [15:0] Data_din,
  output logic [15:0] memout,
  output logic        busy,
  output logic        done,
  output logic        err
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] WAIT_MAX = CW'(TIMEOUT - 1);

  typedef enum logic [2:0] {IDLE, IND, RD, WR, DONE} state_t;

  state_t        state_q, state_d;
  logic [15:0]   addr_q, addr_d;
  logic [15:0]   data_q, data_d;
  logic [1:0]    op_q, op_d;
  logic [CW-1:0] wait_q, wait_d;
  logic [15:0]   memout_q, memout_d;
  logic          err_q, err_d;

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    data_d   = data_q;
    op_d     = op_q;
    wait_d   = wait_q;
    memout_d = memout_q;
    err_d    = err_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          addr_d = M_Addr;
          data_d = M_Data;
          op_d   = mem_op;
          err_d  = 1'b0;
          wait_d = '0;
          unique case (mem_op)
            2'b00:   state_d = RD;
            2'b10:   state_d = WR;
            default: state_d = IND;
          endcase
        end
      end
      IND, RD, WR: begin
        if (Data_ready) begin
          wait_d = '0;
          if (state_q == IND) begin
            // The pointer read replaces the address for the second access.
            addr_d  = Data_dout;
            state_d = (op_q == 2'b11) ? WR : RD;
          end else begin
            if (state_q == RD) memout_d = Data_dout;
            state_d = DONE;
          end
        end else if (wait_q == WAIT_MAX) begin
          err_d   = 1'b1;
          state_d = DONE;
        end else begin
          wait_d = wait_q + 1'b1;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= IDLE;
      addr_q   <= '0;
      data_q   <= '0;
      op_q     <= '0;
      wait_q   <= '0;
      memout_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      op_q     <= op_d;
      wait_q   <= wait_d;
      memout_q <= memout_d;
      err_q    <= err_d;
    end
  end

  // Outputs are pure decodes of registered state.
  assign Data_req  = (state_q == IND) || (state_q == RD) || (state_q == WR);
  assign Data_rd   = (state_q != WR);
  assign busy      = Data_req;
  assign done      = (state_q == DONE);
  assign Data_addr = addr_q;
  assign Data_din  = data_q;
  assign memout    = memout_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mem_access.sv
// tb/tb_mem_access.sv - table-driven scoreboard bench for mem_access with a stalling memory responder.
module tb_mem_access;

  logic        clock;
  logic        reset;
  logic        start;
  logic [1:0]  mem_op;
  logic [15:0] M_Addr;
  logic [15:0] M_Data;
  logic [15:0] Data_dout;
  logic        Data_ready;
  logic        Data_req;
  logic        Data_rd;
  logic [15:0] Data_addr;
  logic [15:0] Data_din;
  logic [15:0] memout;
  logic        busy;
  logic        done;
  logic        err;

  int checks = 0;
  int errors = 0;

  mem_access #(.TIMEOUT(8)) dut (
    .clock(clock), .reset(reset), .start(start), .mem_op(mem_op),
    .M_Addr(M_Addr), .M_Data(M_Data), .Data_dout(Data_dout), .Data_ready(Data_ready),
    .Data_req(Data_req), .Data_rd(Data_rd), .Data_addr(Data_addr), .Data_din(Data_din),
    .memout(memout), .busy(busy), .done(done), .err(err)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got hung expected finish");
    $fatal(1);
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] mem_rd(input logic [15:0] a);
    case (a)
      16'h3005: mem_rd = 16'hBEEF;
      16'h4000: mem_rd = 16'h5000;
      16'h5100: mem_rd = 16'h6000;
      16'h6000: mem_rd = 16'h00FF;
      default:  mem_rd = a ^ 16'hA5A5;
    endcase
  endfunction

  // Memory responder: per-access stall counts, records completed writes.
  int          stalls [2];
  int          left;
  int          acc_idx;
  int          wr_cnt;
  logic [15:0] wr_addr;
  logic [15:0] wr_data;

  initial begin
    Data_ready = 1'b0;
    Data_dout  = 16'h0000;
    left       = -1;
    acc_idx    = 0;
    wr_cnt     = 0;
    wr_addr    = 16'h0000;
    wr_data    = 16'h0000;
    forever begin
      @(negedge clock);
      if (!Data_req) begin
        acc_idx    = 0;
        left       = -1;
        Data_ready = 1'b0;
      end else begin
        if (left < 0) left = (acc_idx < 2) ? stalls[acc_idx] : 0;
        if (left > 0) begin
          Data_ready = 1'b0;
          left--;
        end else begin
          Data_ready = 1'b1;
          Data_dout  = mem_rd(Data_addr);
          if (!Data_rd) begin
            wr_addr = Data_addr;
            wr_data = Data_din;
            wr_cnt++;
          end
          acc_idx++;
          left = -1;
        end
      end
    end
  end

  typedef struct {
    logic [1:0]  op;
    logic [15:0] addr;
    logic [15:0] data;
    int          s0;
    int          s1;
    logic [15:0] memout;
    logic        err;
    int          lat;
    logic        wr;
    logic [15:0] waddr;
  } vec_t;

  typedef struct {
    logic [15:0] memout;
    logic        err;
    int          lat;
    logic        wr;
    logic [15:0] waddr;
    logic [15:0] wdata;
    int          wr_cnt0;
  } exp_t;

  exp_t sb [$];
  vec_t vecs [12];

  // Entered and left just after a falling edge.
  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    int   n;
    int   reqc;
    stalls[0] = v.s0;
    stalls[1] = v.s1;
    e = '{v.memout, v.err, v.lat, v.wr, v.waddr, v.data, wr_cnt};
    sb.push_back(e);
    start  = 1'b1;
    mem_op = v.op;
    M_Addr = v.addr;
    M_Data = v.data;
    @(negedge clock);
    start = 1'b0;
    n     = 1;
    check({tag, " c1 Data_addr"}, Data_addr, v.addr);
    check({tag, " c1 Data_din"}, Data_din, v.data);
    check({tag, " c1 Data_rd"}, {15'b0, Data_rd}, {15'b0, v.op != 2'b10});
    reqc = 0;
    while (!done && n < 40) begin
      if (Data_req) reqc++;
      @(negedge clock);
      n++;
    end
    e = sb.pop_front();
    if (!done) begin
      checks++;
      errors++;
      $display("FAIL %s done: got no done pulse within %0d cycles expected done at %0d", tag, n, e.lat);
    end else begin
      check({tag, " latency"}, 16'(n), 16'(e.lat));
      check({tag, " req cycles"}, 16'(reqc), 16'(e.lat - 1));
      check({tag, " memout"}, memout, e.memout);
      check({tag, " err"}, {15'b0, err}, {15'b0, e.err});
      check({tag, " busy at done"}, {15'b0, busy}, 16'h0000);
      if (e.wr) begin
        check({tag, " write count"}, 16'(wr_cnt), 16'(e.wr_cnt0 + 1));
        check({tag, " write addr"}, wr_addr, e.waddr);
        check({tag, " write data"}, wr_data, e.wdata);
      end else begin
        check({tag, " no write"}, 16'(wr_cnt), 16'(e.wr_cnt0));
      end
    end
    @(negedge clock);
    check({tag, " done one cycle"}, {15'b0, done}, 16'h0000);
  endtask

  initial begin
    int   ndone;
    int   wc0;
    vec_t v;
    reset  = 1'b1;
    start  = 1'b0;
    mem_op = 2'b00;
    M_Addr = 16'h0000;
    M_Data = 16'h0000;
    stalls[0] = 0;
    stalls[1] = 0;
    repeat (2) @(negedge clock);
    check("reset Data_req", {15'b0, Data_req}, 16'h0000);
    check("reset Data_rd", {15'b0, Data_rd}, 16'h0001);
    check("reset Data_addr", Data_addr, 16'h0000);
    check("reset Data_din", Data_din, 16'h0000);
    check("reset memout", memout, 16'h0000);
    check("reset busy", {15'b0, busy}, 16'h0000);
    check("reset done", {15'b0, done}, 16'h0000);
    check("reset err", {15'b0, err}, 16'h0000);
    reset = 1'b0;
    @(negedge clock);

    vecs[0]  = '{2'b00, 16'h3005, 16'h0000, 0, 0, 16'hBEEF, 1'b0, 2,  1'b0, 16'h0000};
    vecs[1]  = '{2'b10, 16'h1111, 16'hCAFE, 0, 0, 16'hBEEF, 1'b0, 2,  1'b1, 16'h1111};
    vecs[2]  = '{2'b01, 16'h5100, 16'h0000, 0, 3, 16'h00FF, 1'b0, 6,  1'b0, 16'h0000};
    vecs[3]  = '{2'b11, 16'h4000, 16'h1234, 0, 0, 16'h00FF, 1'b0, 3,  1'b1, 16'h5000};
    vecs[4]  = '{2'b00, 16'h0123, 16'h0000, 2, 0, 16'hA486, 1'b0, 4,  1'b0, 16'h0000};
    vecs[5]  = '{2'b01, 16'hFFFF, 16'h0000, 1, 1, 16'hFFFF, 1'b0, 5,  1'b0, 16'h0000};
    vecs[6]  = '{2'b10, 16'h2222, 16'h0F0F, 7, 0, 16'hFFFF, 1'b0, 9,  1'b1, 16'h2222};
    vecs[7]  = '{2'b10, 16'h7000, 16'h5555, 8, 0, 16'hFFFF, 1'b1, 9,  1'b0, 16'h0000};
    vecs[8]  = '{2'b00, 16'h0000, 16'h0000, 0, 0, 16'hA5A5, 1'b0, 2,  1'b0, 16'h0000};
    vecs[9]  = '{2'b01, 16'h3005, 16'h0000, 8, 0, 16'hA5A5, 1'b1, 9,  1'b0, 16'h0000};
    vecs[10] = '{2'b11, 16'h4000, 16'hABCD, 0, 8, 16'hA5A5, 1'b1, 10, 1'b0, 16'h0000};
    vecs[11] = '{2'b00, 16'h3005, 16'h0000, 0, 0, 16'hBEEF, 1'b0, 2,  1'b0, 16'h0000};

    for (int i = 0; i < 12; i++) begin
      run_vec(vecs[i], $sformatf("vec%0d", i));
    end

    // Reset in the middle of a read wait.
    stalls[0] = 5;
    stalls[1] = 0;
    start  = 1'b1;
    mem_op = 2'b00;
    M_Addr = 16'h6000;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    check("midreset pre Data_req", {15'b0, Data_req}, 16'h0001);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("midreset Data_req", {15'b0, Data_req}, 16'h0000);
    check("midreset busy", {15'b0, busy}, 16'h0000);
    check("midreset memout", memout, 16'h0000);
    check("midreset done", {15'b0, done}, 16'h0000);
    v = '{2'b00, 16'h3005, 16'h0000, 0, 0, 16'hBEEF, 1'b0, 2, 1'b0, 16'h0000};
    run_vec(v, "after_reset");

    // start pulsed while busy must be dropped.
    stalls[0] = 4;
    stalls[1] = 0;
    wc0    = wr_cnt;
    start  = 1'b1;
    mem_op = 2'b00;
    M_Addr = 16'h6000;
    @(negedge clock);
    start = 1'b0;
    @(negedge clock);
    start  = 1'b1;
    mem_op = 2'b10;
    M_Addr = 16'h9999;
    @(negedge clock);
    start = 1'b0;
    check("busy start Data_addr", Data_addr, 16'h6000);
    check("busy start Data_rd", {15'b0, Data_rd}, 16'h0001);
    ndone = 0;
    for (int k = 0; k < 12; k++) begin
      if (done) ndone++;
      @(negedge clock);
    end
    check("busy start done pulses", 16'(ndone), 16'd1);
    check("busy start memout", memout, 16'h00FF);
    check("busy start no write", 16'(wr_cnt), 16'(wc0));
    check("busy start idle", {15'b0, busy}, 16'h0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mem_access.md
Name: mem_access

Overview:
- Memory-access stage of the LC-3 pipeline; sits downstream of Execute and consumes its memory-bound results.
- Takes the effective address (pcout or aluout, selected upstream), store data (M_Data) and a memory opcode.
- Runs the data-memory handshake for LD/LDR, LDI, ST/STR and STI. Indirect forms take two memory transactions.
- Returns load data to Writeback and holds the pipeline via busy while a transaction is in flight.

Parameters:
- TIMEOUT, 8: maximum cycles to wait for Data_ready in any access state before aborting (must be >=1).

Ports:
- clock  in  1  pipeline clock.
- reset  in  1  synchronous, active-high.
- start  in  1  one-cycle request from the controller; accepted only in IDLE.
- mem_op  in  2  operation: 00 LD/LDR, 01 LDI, 10 ST/STR, 11 STI.
- M_Addr  in  16  effective address from Execute.
- M_Data  in  16  store data from Execute.
- Data_dout  in  16  read data from data memory.
- Data_ready  in  1  memory completes the current transfer this cycle.
- Data_req  out  1  transfer request to memory.
- Data_rd  out  1  1 = read, 0 = write.
- Data_addr  out  16  memory address.
- Data_din  out  16  memory write data.
- memout  out  16  last load result, to Writeback.
- busy  out  1  transaction in flight; the controller stalls upstream stages.
- done  out  1  one-cycle completion pulse.
- err  out  1  last transaction timed out.

Behaviour:
- Reset values:
  - state IDLE.
  - Data_req 0, Data_rd 1, Data_addr 0, Data_din 0.
  - memout 0, busy 0, done 0, err 0.
  - Internal addr_reg, data_reg, op_reg and wait_cnt all 0.
- Reset mid-operation: state returns to IDLE on that edge and Data_req drops the same edge; no partial result is written to memout.
- States: IDLE, IND, RD, WR, DONE.
- All outputs are decoded from registers only; there are no combinational paths from inputs to outputs.
  - Data_req = 1 in IND, RD, WR.
  - Data_rd = 0 only in WR.
  - busy = 1 in IND, RD, WR.
  - done = 1 only in DONE.
  - Data_addr = addr_reg; Data_din = data_reg.
- IDLE:
  - On start=1: latch addr_reg<=M_Addr, data_reg<=M_Data, op_reg<=mem_op; clear err.
  - Next state: 00 -> RD, 01 -> IND, 10 -> WR, 11 -> IND.
  - start=0: stay in IDLE.
- IND (first read, for LDI/STI):
  - On Data_ready: addr_reg<=Data_dout.
  - Next state: RD if op_reg=01, WR if op_reg=11.
- RD: on Data_ready, memout<=Data_dout; next state DONE.
- WR: on Data_ready, next state DONE. The write is complete in memory at that edge.
- DONE: one cycle; next state IDLE. start is ignored in DONE.
- Timeout:
  - wait_cnt clears on entry to every access state and increments each cycle Data_ready=0.
  - If wait_cnt = TIMEOUT-1 and Data_ready=0: go to DONE with err<=1; memout unchanged; a pending second access of an indirect op is skipped.
  - err holds until the next accepted start.
- Data_ready in IDLE or DONE is ignored.
- start in IND/RD/WR/DONE is ignored; the request is not queued. The controller must hold off while busy or done.
- Latency with Data_ready tied high (start accepted at cycle 0):
  - LD/ST: access at cycle 1, done and memout valid at cycle 2.
  - LDI/STI: IND at cycle 1, second access at cycle 2, done at cycle 3.
  - Each wait cycle adds 1.
- Addresses are full 16-bit, and Data_dout is used unmodified as the indirect pointer (wraps naturally).

Test Plan:
- Reset, then LD: start, mem_op=00, M_Addr=0x3005, Data_ready=1, Data_dout=0xBEEF -> Data_req=1 with Data_addr=0x3005, Data_rd=1 at cycle 1; memout=0xBEEF and done=1 at cycle 2; busy=0 at cycle 2.
- STI: M_Addr=0x4000, M_Data=0x1234; first read returns 0x5000 -> cycle 1 read at 0x4000; cycle 2 Data_rd=0, Data_addr=0x5000, Data_din=0x1234; done at cycle 3; memout unchanged.
- LDI with Data_ready held low for 3 cycles in RD, pointer 0x6000, final data 0x00FF -> busy stays 1 through the waits; memout=0x00FF; done at cycle 6.
- Timeout, TIMEOUT=8: ST to 0x7000 with Data_ready never asserted -> Data_req high exactly 8 cycles, then done=1, err=1. A following LD clears err on its accepted start.
- Reset asserted in the RD wait cycle -> Data_req=0 and state IDLE after that edge, memout=0; a new start is accepted the next cycle.
- start pulsed while busy with a different M_Addr -> ignored; the in-flight Data_addr is unchanged and exactly one done pulse occurs.
